tappy_rx: RTL and testbench
===========================

Name: tappy_rx

Overview:
- Parametrised successor to the tappy PS/2-style receiver.
- Oversamples the external `clk`/`dat` pair on `sysclk`, which runs at least 4x the maximum line frequency.
- Deframes start/data/parity/stop and pushes good words into a small output FIFO with a valid/ready handshake.
- Adds configurable width, parity mode, per-frame error reporting, a bit-gap timeout and overflow detection.
- Sits between the keyboard-side pins and the host logic that consumes `word`.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first, legal range 5..9.
- PARITY, 1, parity mode: 0 none, 1 odd, 2 even.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- TIMEOUT, 256, maximum `sysclk` cycles allowed between line-clock falling edges inside a frame.
- SYNC_STAGES, 2, synchroniser flops on `clk` and `dat`; minimum 2.

Ports:
- sysclk  in  1  system clock; sole clock domain.
- reset  in  1  asynchronous, active-low reset.
- clk  in  1  external line clock, asynchronous to `sysclk`.
- dat  in  1  external line data, asynchronous to `sysclk`.
- inhibit  in  1  high = ignore the line and abandon any partial frame.
- word  out  DATA_BITS  FIFO head data.
- done  out  1  FIFO non-empty; `word` is valid.
- ready  in  1  consumer accepts `word` when `done && ready`.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_parity  out  1  one-cycle pulse: parity mismatch, frame dropped.
- err_frame  out  1  one-cycle pulse: stop bit sampled 0, frame dropped.
- err_timeout  out  1  one-cycle pulse: frame abandoned on a bit gap.
- overflow  out  1  one-cycle pulse: good frame dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; `word` = 0; FIFO empty.
  - FSM goes to IDLE; synchronisers are preset to 1 (idle line).
  - Reset takes effect mid-frame or mid-handshake with no partial push.
- Sampling:
  - `clk` and `dat` each pass through SYNC_STAGES flops.
  - A falling edge is detected when the synchronised clk was 1 last cycle and is 0 this cycle.
  - `dat` is sampled in that same cycle.
- FSM (advances only on a detected falling edge, except for timeout and inhibit):
  - IDLE: sampled dat=0 → DATA, bit counter cleared, timer cleared. Sampled dat=1 → stay IDLE, no error (glitch rejection).
  - DATA: shift the sampled bit into position [cnt], LSB first. After DATA_BITS bits → PARITY, or → STOP when PARITY=0.
  - PARITY: compare the sampled bit with the computed parity → STOP; the result is held until STOP.
  - STOP:
    - sampled 0 → err_frame pulse (frame_err takes priority over a parity result) → IDLE.
    - parity mismatch → err_parity pulse → IDLE.
    - otherwise push the word → IDLE.
  - Odd parity: the data bits plus the parity bit contain an odd number of ones. Even parity: an even number.
- Timeout:
  - In any state other than IDLE, the timer counts `sysclk` cycles and clears on every falling edge.
  - When the timer reaches TIMEOUT: err_timeout pulses for one cycle, the FSM goes to IDLE, and the partial word is discarded.
- Inhibit:
  - While inhibit=1 the FSM is forced to IDLE, the timer is cleared, edges are ignored, and no error is raised.
  - The FIFO output side keeps operating.
- Latency: the cycle after the stop-bit falling edge is detected, `done` is 1 and `word` is valid (when the FIFO was empty).
- FIFO:
  - First-word-fall-through; pop occurs on `done && ready`.
  - Push while full: the word is dropped, overflow pulses, and contents are unchanged.
  - Push and pop in the same cycle while full: the pop is accepted first and the push succeeds; level is unchanged and there is no overflow.
  - Push and pop in the same cycle while empty: impossible, since `done` is 0.
  - `level` saturates at FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- Error pulses are mutually exclusive within a frame and never coincide with a push.

Test Plan:
- Defaults, line clock 12.5 kHz (80 us bit period), frame 0xA5 with parity bit 1 and stop 1, ready=1: `done` pulses for one cycle with word=0xA5; no error pulses.
- Same frame with parity bit 0: err_parity pulses once; `done` stays 0; level stays 0.
- ready=0, five good frames 0x01..0x05: level reaches 4; overflow pulses once, on the 5th frame. Raising ready then pops 0x01, 0x02, 0x03, 0x04 in order, and level returns to 0.
- Line clock stopped after 4 data bits of 0x3C: err_timeout pulses 256 ±1 cycles after the last edge. A following full 0x3C frame is received correctly.
- inhibit raised after 3 bits and released, then a full 0x7E frame: no error pulses; only 0x7E appears.
- reset asserted mid-frame with 2 words queued: all outputs go to 0 immediately. After release, the next frame 0x55 is received as the sole word.
- Stop bit driven 0 on frame 0x12: err_frame pulses; nothing is pushed.
- PARITY=2, DATA_BITS=7, frame 0x41 with parity bit 0 and stop 1: word=0x41; no error pulses.

Source files
------------

// File: rtl/tappy_rx.sv
// tappy_rx - oversampling PS/2-style line receiver with an output FIFO.
//
// The external clk/dat pair is synchronised into the sysclk domain. Falling
// edges of the line clock drive a start/data/parity/stop deframer. Good words
// are queued in a first-word-fall-through FIFO with a valid/ready handshake.
//
// Ports:
//   sysclk       system clock, sole clock domain
//   reset        asynchronous active-low reset
//   clk, dat     external line clock and data (asynchronous to sysclk)
//   inhibit      high = ignore the line and abandon any partial frame
//   word         FIFO head data (0 while the FIFO is empty)
//   done         FIFO non-empty; word is valid
//   ready        consumer accepts word when done && ready
//   level        current FIFO occupancy
//   err_parity   one-cycle pulse: parity mismatch, frame dropped
//   err_frame    one-cycle pulse: stop bit sampled 0, frame dropped
//   err_timeout  one-cycle pulse: frame abandoned on a bit gap
//   overflow     one-cycle pulse: good frame dropped, FIFO full
module tappy_rx #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          clk,
  input  logic                          dat,
  input  logic                          inhibit,
  output logic [DATA_BITS-1:0]          word,
  output logic                          done,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_timeout,
  output logic                          overflow
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_BITS);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------------------------------------------------------- sampling
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] dat_sync_reg;
  logic                   clk_prev_reg;
  logic                   clk_s;
  logic                   bit_s;
  logic                   fall;

  // Presetting to 1 makes reset look like an idle line, so no false edge.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      clk_sync_reg <= '1;
      dat_sync_reg <= '1;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], clk};
      dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], dat};
      clk_prev_reg <= clk_s;
    end
  end

  assign clk_s = clk_sync_reg[SYNC_STAGES-1];
  assign bit_s = dat_sync_reg[SYNC_STAGES-1];
  assign fall  = clk_prev_reg & ~clk_s;

  // ---------------------------------------------------------------- deframer
  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 perr_reg, perr_next;
  logic                 push;
  logic                 perr_pulse, ferr_pulse, tout_pulse;
  logic                 exp_par;

  // Parity bit the sender should have used; data_reg is complete by S_PAR.
  assign exp_par = (PARITY == 1) ? ~(^data_reg) : (^data_reg);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      timer_reg <= '0;
      data_reg  <= '0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      timer_reg <= timer_next;
      data_reg  <= data_next;
      perr_reg  <= perr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    timer_next = timer_reg;
    data_next  = data_reg;
    perr_next  = perr_reg;
    push       = 1'b0;
    perr_pulse = 1'b0;
    ferr_pulse = 1'b0;
    tout_pulse = 1'b0;
    if (inhibit) begin
      state_next = S_IDLE;
      timer_next = '0;
    end else if (fall) begin
      timer_next = '0;
      case (state_reg)
        S_IDLE: begin
          // A high sample on an edge is treated as a glitch, not a start bit.
          if (!bit_s) begin
            state_next = S_DATA;
            cnt_next   = '0;
            perr_next  = 1'b0;
          end
        end
        S_DATA: begin
          data_next[cnt_reg] = bit_s;
          if (cnt_reg == CW'(DATA_BITS - 1)) begin
            state_next = (PARITY == 0) ? S_STOP : S_PAR;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        S_PAR: begin
          perr_next  = (bit_s != exp_par);
          state_next = S_STOP;
        end
        S_STOP: begin
          state_next = S_IDLE;
          if (!bit_s) begin
            ferr_pulse = 1'b1;
          end else if (perr_reg) begin
            perr_pulse = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end else if (state_reg != S_IDLE) begin
      if (timer_reg == TW'(TIMEOUT - 1)) begin
        tout_pulse = 1'b1;
        state_next = S_IDLE;
        timer_next = '0;
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]        count_reg;
  logic                 full;
  logic                 pop;
  logic                 push_ok;

  assign full    = (count_reg == LW'(FIFO_DEPTH));
  assign pop     = done & ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge sysclk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= data_reg;
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg   <= count_reg + LW'(push_ok) - LW'(pop);
      err_parity  <= perr_pulse;
      err_frame   <= ferr_pulse;
      err_timeout <= tout_pulse;
      overflow    <= push & full & ~pop;
    end
  end

  assign done  = (count_reg != '0);
  assign level = count_reg;
  // Mask the uninitialised array so word reads 0 whenever nothing is queued.
  assign word  = done ? mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_tappy_rx.sv
// Testbench for tappy_rx: a default instance (8 data bits, odd parity) and a
// second instance with 7 data bits and even parity. The line clock runs with
// a half period of H sysclk cycles, well above the 4x oversampling minimum.
module tb_tappy_rx;

  localparam int H = 8;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       lclk   = 1'b1;
  logic       ldat   = 1'b1;
  logic       inhibit = 1'b0;
  logic       ready  = 1'b1;
  logic [7:0] word;
  logic       done;
  logic [2:0] level;
  logic       err_parity, err_frame, err_timeout, overflow;

  logic       lclk2  = 1'b1;
  logic       ldat2  = 1'b1;
  logic       inhibit2 = 1'b0;
  logic       ready2 = 1'b1;
  logic [6:0] word2;
  logic       done2;
  logic [2:0] level2;
  logic       err_parity2, err_frame2, err_timeout2, overflow2;

  always #5 sysclk = ~sysclk;

  tappy_rx dut (
    .sysclk(sysclk), .reset(reset), .clk(lclk), .dat(ldat), .inhibit(inhibit),
    .word(word), .done(done), .ready(ready), .level(level),
    .err_parity(err_parity), .err_frame(err_frame),
    .err_timeout(err_timeout), .overflow(overflow)
  );

  tappy_rx #(.DATA_BITS(7), .PARITY(2)) dut2 (
    .sysclk(sysclk), .reset(reset), .clk(lclk2), .dat(ldat2), .inhibit(inhibit2),
    .word(word2), .done(done2), .ready(ready2), .level(level2),
    .err_parity(err_parity2), .err_frame(err_frame2),
    .err_timeout(err_timeout2), .overflow(overflow2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall = 0;

  // Observed events, gathered away from the active edge.
  int n_perr = 0, n_ferr = 0, n_tout = 0, n_ovf = 0, n_done = 0, n_err2 = 0;
  int tout_cyc = 0;
  logic [8:0] got_q[$];
  logic [8:0] got2_q[$];

  always @(posedge sysclk) cyc++;

  always @(negedge sysclk) begin
    if (done) n_done++;
    if (done && ready) got_q.push_back({1'b0, word});
    if (err_parity) n_perr++;
    if (err_frame) n_ferr++;
    if (err_timeout) begin n_tout++; tout_cyc = cyc; end
    if (overflow) n_ovf++;
    if (done2 && ready2) got2_q.push_back({2'b0, word2});
    if (err_parity2 || err_frame2 || err_timeout2 || overflow2) n_err2++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Parity bit a correct sender transmits: mode 1 odd, mode 2 even.
  function automatic logic good_par(input logic [8:0] d, input int nd, input int mode);
    int ones = 0;
    for (int i = 0; i < nd; i++) ones += int'(d[i]);
    return (mode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic drive_bit(input int line, input logic b);
    if (line == 0) ldat = b; else ldat2 = b;
    wait_cyc(H);
    if (line == 0) begin lclk = 1'b0; last_fall = cyc; end else lclk2 = 1'b0;
    wait_cyc(H);
    if (line == 0) lclk = 1'b1; else lclk2 = 1'b1;
  endtask

  // Sends start, nd data bits LSB first, optional parity, stop; only the
  // first nsend bits go out, so a partial frame is just a small nsend.
  task automatic send_frame(input int line, input logic [8:0] d, input int nd,
                            input logic par_en, input logic par_bit,
                            input logic stop_bit, input int nsend);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(d[i]);
    if (par_en) bits.push_back(par_bit);
    bits.push_back(stop_bit);
    for (int i = 0; i < nsend && i < bits.size(); i++) drive_bit(line, bits[i]);
    if (line == 0) ldat = 1'b1; else ldat2 = 1'b1;
    wait_cyc(2 * H);
  endtask

  task automatic send_good(input logic [8:0] d);
    send_frame(0, d, 8, 1'b1, good_par(d, 8, 1), 1'b1, 99);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    reset = 1'b0;
    wait_cyc(2);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (word !== 8'h00) begin bad++; $display("FAIL reset_word got=%h want=00", word); end
    total++; if ({err_parity, err_frame, err_timeout, overflow} !== 4'b0) begin
      bad++; $display("FAIL reset_errs got=%b want=0000", {err_parity, err_frame, err_timeout, overflow});
    end
    total++; if ({done2, word2} !== 8'h00) begin bad++; $display("FAIL reset_dut2 got=%h want=00", {done2, word2}); end
    reset = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_good_frame;
    int e0 = n_perr + n_ferr + n_tout + n_ovf;
    int d0 = n_done;
    got_q.delete();
    send_good(9'h0A5);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL good_count got=%0d want=1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 9'h0A5) begin bad++; $display("FAIL good_word got=%h want=a5", got_q[0]); end
    end
    total++; if (n_done - d0 != 1) begin bad++; $display("FAIL good_done_cycles got=%0d want=1", n_done - d0); end
    total++; if (n_perr + n_ferr + n_tout + n_ovf - e0 != 0) begin
      bad++; $display("FAIL good_errs got=%0d want=0", n_perr + n_ferr + n_tout + n_ovf - e0);
    end
    $display("good frame a5: words=%0d", got_q.size());
  endtask

  task automatic test_parity_err;
    int p0 = n_perr;
    got_q.delete();
    send_frame(0, 9'h0A5, 8, 1'b1, 1'b0, 1'b1, 99);
    total++; if (n_perr - p0 != 1) begin bad++; $display("FAIL parity_pulse got=%0d want=1", n_perr - p0); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL parity_words got=%0d want=0", got_q.size()); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL parity_level got=%0d want=0", level); end
    $display("parity error frame a5: pulses=%0d", n_perr - p0);
  endtask

  task automatic test_random;
    logic [8:0] exp_q[$];
    int exp_p = 0, exp_f = 0;
    int p0 = n_perr, f0 = n_ferr;
    got_q.delete();
    for (int k = 0; k < 10; k++) begin
      logic [8:0] d;
      int kind;
      logic pb, sb;
      d    = 9'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 3));
      pb   = good_par(d, 8, 1);
      if (kind == 2) pb = ~pb;
      sb   = (kind == 3) ? 1'b0 : 1'b1;
      send_frame(0, d, 8, 1'b1, pb, sb, 99);
      if (!sb) exp_f++;
      else if (kind == 2) exp_p++;
      else exp_q.push_back(d);
      $display("random frame %0d: data=%h kind=%0d", k, d, kind);
    end
    total++; if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL random_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++; if (got_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL random_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
        end
      end
    end
    total++; if (n_perr - p0 != exp_p) begin bad++; $display("FAIL random_perr got=%0d want=%0d", n_perr - p0, exp_p); end
    total++; if (n_ferr - f0 != exp_f) begin bad++; $display("FAIL random_ferr got=%0d want=%0d", n_ferr - f0, exp_f); end
  endtask

  task automatic test_overflow;
    int o0 = n_ovf;
    got_q.delete();
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_good(9'(k));
      $display("overflow fill frame %0d: level=%0d", k, level);
      if (k == 4) begin
        total++; if (n_ovf - o0 != 0) begin bad++; $display("FAIL ovf_early got=%0d want=0", n_ovf - o0); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level4 got=%0d want=4", level); end
      end
    end
    total++; if (n_ovf - o0 != 1) begin bad++; $display("FAIL ovf_pulse got=%0d want=1", n_ovf - o0); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level_full got=%0d want=4", level); end
    ready = 1'b1;
    wait_cyc(8);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL ovf_drain got=%0d want=4", got_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (got_q[i] !== 9'(i + 1)) begin
          bad++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, got_q[i], 9'(i + 1));
        end
      end
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL ovf_level_end got=%0d want=0", level); end
  endtask

  task automatic test_timeout;
    int t0 = n_tout;
    int waited = 0;
    int delta;
    got_q.delete();
    send_frame(0, 9'h03C, 8, 1'b1, good_par(9'h03C, 8, 1), 1'b1, 5);
    while (n_tout == t0 && waited < 400) begin
      wait_cyc(1);
      waited++;
    end
    total++; if (n_tout == t0) begin
      bad++; $display("FAIL timeout_missing got=0 want=1 pulse");
    end else begin
      delta = tout_cyc - last_fall;
      // Two synchroniser stages plus the edge register add three cycles.
      total++; if (delta < 257 || delta > 261) begin
        bad++; $display("FAIL timeout_delay got=%0d want=259+-2", delta);
      end
      $display("timeout pulse %0d cycles after last line edge", delta);
    end
    wait_cyc(4);
    total++; if (n_tout - t0 != 1) begin bad++; $display("FAIL timeout_count got=%0d want=1", n_tout - t0); end
    send_good(9'h03C);
    total++; if (got_q.size() != 1 || got_q[0] !== 9'h03C) begin
      bad++; $display("FAIL timeout_recover got_n=%0d want 1 word 3c", got_q.size());
    end
  endtask

  task automatic test_inhibit;
    int e0 = n_perr + n_ferr + n_tout + n_ovf;
    got_q.delete();
    send_frame(0, 9'h07E, 8, 1'b1, good_par(9'h07E, 8, 1), 1'b1, 3);
    inhibit = 1'b1;
    wait_cyc(20);
    inhibit = 1'b0;
    wait_cyc(4);
    send_good(9'h07E);
    wait_cyc(300);
    total++; if (n_perr + n_ferr + n_tout + n_ovf - e0 != 0) begin
      bad++; $display("FAIL inhibit_errs got=%0d want=0", n_perr + n_ferr + n_tout + n_ovf - e0);
    end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL inhibit_count got=%0d want=1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 9'h07E) begin bad++; $display("FAIL inhibit_word got=%h want=7e", got_q[0]); end
    end
    $display("inhibit then frame 7e: words=%0d", got_q.size());
  endtask

  task automatic test_reset_mid;
    int e0;
    ready = 1'b0;
    send_good(9'h011);
    send_good(9'h022);
    total++; if (level !== 3'd2) begin bad++; $display("FAIL rstmid_level got=%0d want=2", level); end
    send_frame(0, 9'h033, 8, 1'b1, 1'b0, 1'b1, 4);
    reset = 1'b0;
    #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%0b want=0", done); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rstmid_level0 got=%0d want=0", level); end
    total++; if (word !== 8'h00) begin bad++; $display("FAIL rstmid_word got=%h want=00", word); end
    wait_cyc(3);
    reset = 1'b1;
    ready = 1'b1;
    wait_cyc(4);
    got_q.delete();
    e0 = n_perr + n_ferr + n_tout + n_ovf;
    send_good(9'h055);
    total++; if (got_q.size() != 1 || got_q[0] !== 9'h055) begin
      bad++; $display("FAIL rstmid_next got_n=%0d want 1 word 55", got_q.size());
    end
    total++; if (n_perr + n_ferr + n_tout + n_ovf - e0 != 0) begin
      bad++; $display("FAIL rstmid_errs got=%0d want=0", n_perr + n_ferr + n_tout + n_ovf - e0);
    end
    $display("reset mid-frame then 55: words=%0d", got_q.size());
  endtask

  task automatic test_frame_err;
    int f0 = n_ferr, p0 = n_perr;
    got_q.delete();
    send_frame(0, 9'h012, 8, 1'b1, good_par(9'h012, 8, 1), 1'b0, 99);
    total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL frame_pulse got=%0d want=1", n_ferr - f0); end
    total++; if (n_perr - p0 != 0) begin bad++; $display("FAIL frame_perr got=%0d want=0", n_perr - p0); end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL frame_words got=%0d want=0", got_q.size()); end
    $display("bad stop frame 12: frame errors=%0d", n_ferr - f0);
  endtask

  task automatic test_even7;
    logic [8:0] exp_q[$];
    int e0 = n_err2;
    got2_q.delete();
    send_frame(1, 9'h041, 7, 1'b1, good_par(9'h041, 7, 2), 1'b1, 99);
    exp_q.push_back(9'h041);
    for (int k = 0; k < 4; k++) begin
      logic [8:0] d;
      d = 9'($urandom_range(0, 127));
      send_frame(1, d, 7, 1'b1, good_par(d, 7, 2), 1'b1, 99);
      exp_q.push_back(d);
      $display("even7 frame: data=%h", d);
    end
    total++; if (got2_q.size() != exp_q.size()) begin
      bad++; $display("FAIL even7_count got=%0d want=%0d", got2_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        total++; if (got2_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL even7_word[%0d] got=%h want=%h", i, got2_q[i], exp_q[i]);
        end
      end
    end
    total++; if (n_err2 - e0 != 0) begin bad++; $display("FAIL even7_errs got=%0d want=0", n_err2 - e0); end
    send_frame(1, 9'h041, 7, 1'b1, ~good_par(9'h041, 7, 2), 1'b1, 99);
    total++; if (n_err2 - e0 != 1) begin bad++; $display("FAIL even7_bad_par got=%0d want=1", n_err2 - e0); end
    total++; if (got2_q.size() != exp_q.size()) begin
      bad++; $display("FAIL even7_bad_pushed got=%0d want=%0d", got2_q.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_random();
    test_overflow();
    test_timeout();
    test_inhibit();
    test_reset_mid();
    test_frame_err();
    test_even7();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
